// File: rtl/arb_fifo_bridge.sv
// First-word-fall-through FIFO between an arbiter write port and a downstream consumer,
// with accepted-word and dropped-word counters.
module arb_fifo_bridge #(
  parameter int unsigned DEPTH           = 16,
  parameter int unsigned NEAR_FULL_LEVEL = 12
) (
  input  logic                     BUS_CLK,
  input  logic                     BUS_RST_N,
  input  logic                     CLEAR,
  input  logic                     ARB_WRITE,
  input  logic [31:0]              ARB_DATA,
  output logic                     ARB_READY,
  output logic                     FIFO_FULL,
  output logic                     FIFO_NEAR_FULL,
  output logic                     OUT_VALID,
  output logic [31:0]              OUT_DATA,
  input  logic                     OUT_READY,
  output logic [$clog2(DEPTH):0]   FILL_LEVEL,
  output logic [31:0]              WORD_COUNT,
  output logic [7:0]               LOST_COUNT
);

  localparam int unsigned AddrW = $clog2(DEPTH);
  localparam int unsigned PtrW  = AddrW + 1;

  localparam logic [AddrW:0] FullLvl = {1'b1, {AddrW{1'b0}}};
  localparam logic [AddrW:0] NearLvl = NEAR_FULL_LEVEL[AddrW:0];

  logic [31:0]     mem [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [31:0]     word_count_q, word_count_d;
  logic [7:0]      lost_count_q, lost_count_d;

  logic [PtrW-1:0] fill;
  logic            full;
  logic            empty;
  logic            wr_en;
  logic            drop;
  logic            pop;

  // Status is derived from registered pointers only, so ARB_READY has no path from OUT_READY.
  always_comb begin
    fill  = wr_ptr_q - rd_ptr_q;
    full  = (fill == FullLvl);
    empty = (wr_ptr_q == rd_ptr_q);
    wr_en = ARB_WRITE & ~full & ~CLEAR;
    drop  = ARB_WRITE & full & ~CLEAR;
    pop   = OUT_READY & ~empty & ~CLEAR;
  end

  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    word_count_d = word_count_q;
    lost_count_d = lost_count_q;
    if (CLEAR) begin
      wr_ptr_d     = '0;
      rd_ptr_d     = '0;
      word_count_d = '0;
      lost_count_d = '0;
    end else begin
      if (wr_en) begin
        wr_ptr_d     = wr_ptr_q + 1'b1;
        word_count_d = word_count_q + 32'd1;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      if (drop && (lost_count_q != 8'hFF)) begin
        lost_count_d = lost_count_q + 8'd1;
      end
    end
  end

  always_ff @(posedge BUS_CLK or negedge BUS_RST_N) begin
    if (!BUS_RST_N) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      word_count_q <= '0;
      lost_count_q <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      word_count_q <= word_count_d;
      lost_count_q <= lost_count_d;
    end
  end

  // Storage is intentionally not reset; stale words are unreachable once pointers clear.
  always_ff @(posedge BUS_CLK) begin
    if (wr_en) begin
      mem[wr_ptr_q[AddrW-1:0]] <= ARB_DATA;
    end
  end

  always_comb begin
    ARB_READY      = ~full;
    FIFO_FULL      = full;
    FIFO_NEAR_FULL = (fill >= NearLvl);
    OUT_VALID      = ~empty;
    OUT_DATA       = mem[rd_ptr_q[AddrW-1:0]];
    FILL_LEVEL     = fill;
    WORD_COUNT     = word_count_q;
    LOST_COUNT     = lost_count_q;
  end

endmodule

// File: tb/tb_arb_fifo_bridge.sv
// Directed-plus-random bench for arb_fifo_bridge, checked against a queue-based model.
module tb_arb_fifo_bridge;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned NFL   = 12;

  logic        BUS_CLK = 1'b0;
  logic        BUS_RST_N;
  logic        CLEAR;
  logic        ARB_WRITE;
  logic [31:0] ARB_DATA;
  logic        ARB_READY;
  logic        FIFO_FULL;
  logic        FIFO_NEAR_FULL;
  logic        OUT_VALID;
  logic [31:0] OUT_DATA;
  logic        OUT_READY;
  logic [4:0]  FILL_LEVEL;
  logic [31:0] WORD_COUNT;
  logic [7:0]  LOST_COUNT;

  arb_fifo_bridge #(.DEPTH(DEPTH), .NEAR_FULL_LEVEL(NFL)) dut (
    .BUS_CLK        (BUS_CLK),
    .BUS_RST_N      (BUS_RST_N),
    .CLEAR          (CLEAR),
    .ARB_WRITE      (ARB_WRITE),
    .ARB_DATA       (ARB_DATA),
    .ARB_READY      (ARB_READY),
    .FIFO_FULL      (FIFO_FULL),
    .FIFO_NEAR_FULL (FIFO_NEAR_FULL),
    .OUT_VALID      (OUT_VALID),
    .OUT_DATA       (OUT_DATA),
    .OUT_READY      (OUT_READY),
    .FILL_LEVEL     (FILL_LEVEL),
    .WORD_COUNT     (WORD_COUNT),
    .LOST_COUNT     (LOST_COUNT)
  );

  always #5 BUS_CLK = ~BUS_CLK;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] mq[$];
  logic [31:0] m_words = '0;
  int          m_lost = 0;
  logic [31:0] sent[$];
  logic [31:0] seen[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_words = '0;
    m_lost  = 0;
  endtask

  // Apply one clock edge to the model using the rules of the bridge, then to the DUT.
  task automatic tick();
    bit was_full;
    if (CLEAR) begin
      model_reset();
    end else begin
      was_full = (mq.size() == DEPTH);
      if (OUT_READY && mq.size() != 0) void'(mq.pop_front());
      if (ARB_WRITE) begin
        if (was_full) begin
          if (m_lost < 255) m_lost++;
        end else begin
          mq.push_back(ARB_DATA);
          m_words = m_words + 32'd1;
        end
      end
    end
    @(posedge BUS_CLK);
    #1;
  endtask

  task automatic check_all(input string tag);
    check({tag, ".fill"},  32'(FILL_LEVEL), 32'(mq.size()));
    check({tag, ".valid"}, 32'(OUT_VALID), 32'(mq.size() != 0));
    check({tag, ".full"},  32'(FIFO_FULL), 32'(mq.size() == DEPTH));
    check({tag, ".nfull"}, 32'(FIFO_NEAR_FULL), 32'(mq.size() >= NFL));
    check({tag, ".ready"}, 32'(ARB_READY), 32'(mq.size() != DEPTH));
    check({tag, ".words"}, WORD_COUNT, m_words);
    check({tag, ".lost"},  32'(LOST_COUNT), 32'(m_lost));
    if (mq.size() != 0) check({tag, ".data"}, OUT_DATA, mq[0]);
  endtask

  task automatic do_clear();
    CLEAR = 1'b1;
    tick();
    CLEAR = 1'b0;
    check_all("clear");
  endtask

  initial begin
    int guard;
    BUS_RST_N = 1'b0;
    CLEAR     = 1'b0;
    ARB_WRITE = 1'b0;
    ARB_DATA  = '0;
    OUT_READY = 1'b0;
    #1;
    check_all("reset0");
    @(posedge BUS_CLK);
    #1;
    BUS_RST_N = 1'b1;
    check_all("reset1");
    tick();
    check_all("idle");

    // Single word: visible one cycle after the write, not in the same cycle
    ARB_WRITE = 1'b1;
    ARB_DATA  = 32'hDEADBEEF;
    #1;
    check("nobypass", 32'(OUT_VALID), 32'd0);
    tick();
    ARB_WRITE = 1'b0;
    check("single.valid", 32'(OUT_VALID), 32'd1);
    check("single.data", OUT_DATA, 32'hDEADBEEF);
    check("single.words", WORD_COUNT, 32'd1);
    check_all("single");
    OUT_READY = 1'b1;
    tick();
    check_all("single.pop");
    tick();
    check_all("empty.ready");

    // Fill and overflow
    do_clear();
    OUT_READY = 1'b0;
    for (int i = 0; i < 18; i++) begin
      ARB_WRITE = 1'b1;
      ARB_DATA  = $urandom;
      tick();
      check_all("fill");
      check("fill.nf", 32'(FIFO_NEAR_FULL), 32'(i >= 11));
    end
    ARB_WRITE = 1'b0;
    check("ovf.fill", 32'(FILL_LEVEL), 32'd16);
    check("ovf.full", 32'(FIFO_FULL), 32'd1);
    check("ovf.ready", 32'(ARB_READY), 32'd0);
    check("ovf.lost", 32'(LOST_COUNT), 32'd2);
    check("ovf.words", WORD_COUNT, 32'd16);

    // Full with simultaneous pop and write
    ARB_WRITE = 1'b1;
    ARB_DATA  = 32'h5A5A_0001;
    OUT_READY = 1'b1;
    tick();
    ARB_WRITE = 1'b0;
    OUT_READY = 1'b0;
    check("fpw.fill", 32'(FILL_LEVEL), 32'd15);
    check("fpw.lost", 32'(LOST_COUNT), 32'd3);
    check_all("fpw");

    // Wrap-around stream with random back-pressure
    do_clear();
    sent.delete();
    seen.delete();
    guard = 0;
    while ((sent.size() < 40 || mq.size() != 0) && guard < 2000) begin
      ARB_WRITE = (sent.size() < 40) && (mq.size() != DEPTH) && ($urandom_range(0, 3) != 0);
      ARB_DATA  = $urandom;
      OUT_READY = (sent.size() >= 40) || ($urandom_range(0, 1) == 1);
      #1;
      if (ARB_WRITE) sent.push_back(ARB_DATA);
      if (OUT_VALID && OUT_READY) seen.push_back(OUT_DATA);
      tick();
      check_all("stream");
      guard++;
    end
    ARB_WRITE = 1'b0;
    OUT_READY = 1'b0;
    check("stream.timeout", 32'(guard < 2000), 32'd1);
    check("stream.count", 32'(seen.size()), 32'(sent.size()));
    for (int i = 0; i < sent.size() && i < seen.size(); i++) begin
      check("stream.order", seen[i], sent[i]);
    end
    check("stream.words", WORD_COUNT, 32'd40);
    check("stream.fill", 32'(FILL_LEVEL), 32'd0);

    // Lost-count saturation, then CLEAR beats a simultaneous write
    do_clear();
    ARB_WRITE = 1'b1;
    for (int i = 0; i < DEPTH + 300; i++) begin
      ARB_DATA = $urandom;
      tick();
      check_all("sat");
    end
    check("sat.lost", 32'(LOST_COUNT), 32'd255);
    OUT_READY = 1'b1;
    CLEAR     = 1'b1;
    tick();
    CLEAR     = 1'b0;
    ARB_WRITE = 1'b0;
    OUT_READY = 1'b0;
    check("clr.fill", 32'(FILL_LEVEL), 32'd0);
    check("clr.valid", 32'(OUT_VALID), 32'd0);
    check("clr.words", WORD_COUNT, 32'd0);
    check("clr.lost", 32'(LOST_COUNT), 32'd0);
    check_all("clr");

    // Asynchronous reset mid-stream
    for (int i = 0; i < 5; i++) begin
      ARB_WRITE = 1'b1;
      ARB_DATA  = $urandom;
      tick();
    end
    ARB_WRITE = 1'b0;
    check_all("pre_rst");
    #2;
    BUS_RST_N = 1'b0;
    model_reset();
    #1;
    check("arst.valid", 32'(OUT_VALID), 32'd0);
    check("arst.ready", 32'(ARB_READY), 32'd1);
    check_all("arst");
    @(posedge BUS_CLK);
    #1;
    BUS_RST_N = 1'b1;
    ARB_WRITE = 1'b1;
    ARB_DATA  = 32'h1234_5678;
    tick();
    ARB_WRITE = 1'b0;
    check_all("post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/arb_fifo_bridge.md
ARB_FIFO_BRIDGE -- requirements
Module: arb_fifo_bridge

Interface
REQ-001 SHALL provide parameter DEPTH, default 16: FIFO depth in 32-bit words; power of two, at least 4.
REQ-002 SHALL provide parameter NEAR_FULL_LEVEL, default 12: fill level at which FIFO_NEAR_FULL asserts; 1..DEPTH-1.
REQ-003 SHALL have port BUS_CLK  input  1  sole clock; all logic on its rising edge.
REQ-004 SHALL have port BUS_RST_N  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port CLEAR  input  1  synchronous flush of FIFO and counters.
REQ-006 SHALL have port ARB_WRITE  input  1  arbiter write strobe.
REQ-007 SHALL have port ARB_DATA  input  32  arbiter data word.
REQ-008 SHALL have port ARB_READY  output  1  bridge can accept a word this cycle.
REQ-009 SHALL have port FIFO_FULL  output  1  fill level equals DEPTH.
REQ-010 SHALL have port FIFO_NEAR_FULL  output  1  fill level at or above NEAR_FULL_LEVEL.
REQ-011 SHALL have port OUT_VALID  output  1  OUT_DATA holds a valid word.
REQ-012 SHALL have port OUT_DATA  output  32  oldest stored word.
REQ-013 SHALL have port OUT_READY  input  1  downstream consumer accepts OUT_DATA.
REQ-014 SHALL have port FILL_LEVEL  output  log2(DEPTH)+1  current word count, 0..DEPTH.
REQ-015 SHALL have port WORD_COUNT  output  32  total accepted words, wraps modulo 2^32.
REQ-016 SHALL have port LOST_COUNT  output  8  words dropped, saturating at 255.

Function
REQ-017 SHALL drive ARB_READY = not FIFO_FULL, derived from registered pointers only, with no combinational path from OUT_READY.
REQ-018 SHALL accept a write when ARB_WRITE and ARB_READY are both high, storing ARB_DATA at the write pointer.
REQ-019 SHALL drop a word when ARB_WRITE is high and ARB_READY is low, incrementing LOST_COUNT until it saturates at 255 and leaving FIFO contents unchanged.
REQ-020 SHALL operate first-word-fall-through: OUT_VALID = not empty, and OUT_DATA = word at the read pointer.
REQ-021 SHALL pop a word when OUT_VALID and OUT_READY are both high.
REQ-022 SHALL present a word written into an empty FIFO at cycle N as OUT_VALID=1 at cycle N+1 (1-cycle latency), with no same-cycle bypass.
REQ-023 SHALL use read and write pointers of log2(DEPTH)+1 bits that wrap naturally.
REQ-024 SHALL use the MSB of each pointer to distinguish full from empty.
REQ-025 SHALL keep FILL_LEVEL = write pointer - read pointer, in pointer width.
REQ-026 SHALL, on a simultaneous accepted write and pop, leave FILL_LEVEL unchanged and advance both pointers.
REQ-027 SHALL, when full, refuse a write even if a pop occurs in the same cycle; that write counts as lost.
REQ-028 SHALL ignore OUT_READY when empty: no pointer change and no underflow.
REQ-029 SHALL increment WORD_COUNT by one per accepted write, wrapping from 0xFFFFFFFF to 0.
REQ-030 SHALL register FIFO_FULL, FIFO_NEAR_FULL and FILL_LEVEL consistently with the pointers of the same cycle.
REQ-031 SHALL, on CLEAR high, zero both pointers, WORD_COUNT and LOST_COUNT on the next edge.
REQ-032 SHALL give CLEAR precedence over a simultaneous write or pop; neither is counted.

Reset
REQ-033 SHALL, while BUS_RST_N is low, asynchronously force pointers, WORD_COUNT and LOST_COUNT to 0.
REQ-034 SHALL, while BUS_RST_N is low, drive OUT_VALID=0, FIFO_FULL=0, FIFO_NEAR_FULL=0, ARB_READY=1 and FILL_LEVEL=0.
REQ-035 SHALL drive OUT_DATA as don't-care during reset; the memory array itself is not reset.
REQ-036 SHALL discard all stored words on reset mid-operation.
REQ-037 SHALL resume normal operation on the first rising BUS_CLK edge after BUS_RST_N deasserts.

Verification
REQ-038 SHALL verify single word: write 0xDEADBEEF into empty FIFO at cycle N -> OUT_VALID=1 with OUT_DATA=0xDEADBEEF at cycle N+1; WORD_COUNT=1.
REQ-039 SHALL verify fill and overflow: OUT_READY=0, 18 writes -> FILL_LEVEL=16, FIFO_FULL=1, FIFO_NEAR_FULL=1 from the 12th word, ARB_READY=0, LOST_COUNT=2, WORD_COUNT=16.
REQ-040 SHALL verify full with simultaneous pop and write: pop occurs, write is lost, FILL_LEVEL=15, LOST_COUNT increments by 1.
REQ-041 SHALL verify wrap-around: 40 words streamed with random OUT_READY -> output order identical to input order; WORD_COUNT=40; FILL_LEVEL returns to 0.
REQ-042 SHALL verify saturation and CLEAR: 300 writes while full -> LOST_COUNT=255; then CLEAR with ARB_WRITE=1 -> FILL_LEVEL=0, OUT_VALID=0, counters 0.
REQ-043 SHALL verify reset mid-stream: BUS_RST_N low with 5 words stored -> OUT_VALID=0 and ARB_READY=1 immediately, without waiting for a clock edge.
